// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle phase sequencer for the MIPS core.
// Steps each instruction through FETCH -> EXEC1 -> (EXEC2) and stretches a
// phase while the Avalon bus or the multiply/divide unit is stalling.
// Reaching the halt address parks the core in HALT until reset.
//
// Build option: define PERF_COUNT_EN to build the cycle/instruction
// performance counters. Without it both counter outputs are tied to zero
// and no counter logic is built.
module cpu_sequencer #(
    parameter logic RESET_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        pc_halt,
    input  logic        needs_exec2,
    input  logic        mem_access,
    input  logic        muldiv_busy,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic        instr_read,
    output logic        data_enable,
    output logic        stall,
    output logic        active,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC1 = 2'b01,
        S_EXEC2 = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   active_q;
    logic   exec2_stall;

    // EXEC2 cannot retire while its own bus transfer is stalled or the
    // multiply/divide unit is still producing a result.
    assign exec2_stall = (mem_access & waitrequest) | muldiv_busy;

    // Phase strobes and next state; strobes are decoded straight from the
    // current state so that PC/IR/regfile see them in the same cycle.
    always_comb begin
        fetch       = 1'b0;
        exec1       = 1'b0;
        exec2       = 1'b0;
        instr_read  = 1'b0;
        data_enable = 1'b0;
        stall       = 1'b0;
        state_d     = state_q;
        if (reset) begin
            // Reset silences every strobe and restarts at FETCH.
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (pc_halt) begin
                        // Halt wins over a pending bus stall; no read issued.
                        state_d = S_HALT;
                    end else begin
                        instr_read = 1'b1;
                        if (waitrequest) begin
                            stall = 1'b1;
                        end else begin
                            fetch   = 1'b1;
                            state_d = S_EXEC1;
                        end
                    end
                end
                S_EXEC1: begin
                    exec1   = 1'b1;
                    state_d = needs_exec2 ? S_EXEC2 : S_FETCH;
                end
                S_EXEC2: begin
                    exec2       = 1'b1;
                    data_enable = mem_access;
                    stall       = exec2_stall;
                    if (!exec2_stall) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State register and the registered run flag, which drops on the edge
    // that enters HALT and stays low until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            active_q <= RESET_ACTIVE;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) begin
                active_q <= 1'b0;
            end
        end
    end

    assign active = active_q;

`ifdef PERF_COUNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;

    // Counters advance only while the core is running; both wrap naturally.
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_q != S_HALT) begin
            cycle_d = cycle_q + 32'd1;
            if (fetch) begin
                instr_d = instr_q + 32'd1;
            end
        end
    end

    // Performance counter registers, cleared by reset and frozen in HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the MIPS core. It generates the `fetch`, `exec1` and `exec2` phase strobes that drive the program counter, the instruction register, the register file and the ALU. It stretches phases while the Avalon memory bus asserts `waitrequest` or the multiply/divide unit is busy. It halts the core permanently when the program counter reports the halt address.

## Interface
Parameters:
- `RESET_ACTIVE`, default 1: value `active` takes during and after reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `waitrequest`  input  1  Avalon bus stall for the current read/write
- `pc_halt`  input  1  PC reports address 0; valid in FETCH
- `needs_exec2`  input  1  decoder: current instruction uses the EXEC2 phase; sampled in EXEC1
- `mem_access`  input  1  decoder: EXEC2 performs a data bus transaction
- `muldiv_busy`  input  1  multiply/divide unit still computing
- `fetch`  output  1  PC/IR update strobe; one cycle per instruction
- `exec1`  output  1  first execute phase
- `exec2`  output  1  second execute phase; level for the whole EXEC2 state
- `instr_read`  output  1  instruction read request on the bus
- `data_enable`  output  1  data transaction request in EXEC2
- `stall`  output  1  the current phase does not complete this cycle
- `active`  output  1  core running; low once halted
- `cycle_count`  output  32  performance counter (see Configuration)
- `instr_count`  output  32  performance counter (see Configuration)

## Operation
- Four states, 2-bit encoding: FETCH, EXEC1, EXEC2, HALT.
- FETCH:
  - If `pc_halt`: `instr_read`=0, `fetch`=0, next state HALT.
  - Otherwise `instr_read`=1.
  - If `waitrequest`=1: `stall`=1, `fetch`=0, state holds.
  - If `waitrequest`=0: `fetch`=1, next state EXEC1.
- EXEC1: `exec1`=1 for exactly one cycle. Next state EXEC2 if `needs_exec2`, else FETCH.
- EXEC2: `exec2`=1 and `data_enable`=`mem_access`.
  - `stall` = (`mem_access` & `waitrequest`) | `muldiv_busy`.
  - While `stall`=1, state holds. When `stall`=0, next state FETCH.
- HALT: absorbing until reset. All strobes are 0 and `active`=0.
- `active` is registered. It is set to `RESET_ACTIVE` on reset and cleared on the edge that enters HALT.
- `fetch`, `exec1`, `exec2`, `instr_read`, `data_enable` and `stall` are combinational from state and inputs. All of them are forced to 0 while `reset`=1.
- At most one of `fetch`, `exec1`, `exec2` is high in any cycle.

## Timing
- Reset values:
  - state = FETCH, `active` = `RESET_ACTIVE`.
  - `fetch`, `exec1`, `exec2`, `instr_read`, `data_enable`, `stall` are all 0.
  - Both counters are 0.
- First `instr_read` appears in the first cycle after `reset` deasserts.
- Instruction latency with no stalls:
  - 2 cycles (FETCH, EXEC1) without EXEC2.
  - 3 cycles with EXEC2.
  - Each `waitrequest` or `muldiv_busy` cycle adds exactly one cycle.
- Reset mid-instruction from any state, including HALT: the next state is FETCH and no strobe is asserted during the reset cycle.
- `pc_halt` is ignored outside FETCH.
- If `pc_halt` and `waitrequest` are both high in FETCH, `pc_halt` wins: go to HALT.
- If `muldiv_busy` and `waitrequest` are both high in EXEC2, stay until both conditions clear.

## Configuration
- `PERF_COUNT_EN` defined:
  - `cycle_count` increments every non-reset cycle while state ≠ HALT.
  - `instr_count` increments on every cycle with `fetch`=1.
  - Both counters wrap from 0xFFFFFFFF to 0, reset to 0, and freeze in HALT.
- `PERF_COUNT_EN` undefined: both outputs are tied to 0 and no counter logic is built. Ports remain for interface stability.

## Test plan
- Reset, then `waitrequest`=0, `needs_exec2`=0 for 3 instructions:
  - `fetch`/`exec1` alternate; cycle sequence F,E1,F,E1,F,E1.
  - With `PERF_COUNT_EN`: `instr_count`=3, `cycle_count`=6.
- FETCH with `waitrequest` high for 4 cycles:
  - `stall`=1 and `fetch`=0 for 4 cycles, then `fetch`=1 for exactly 1 cycle, then `exec1`.
- Load instruction (`needs_exec2`=1, `mem_access`=1, `waitrequest` high 2 cycles in EXEC2):
  - `exec2` high 3 cycles, `data_enable` high 3 cycles, then FETCH.
  - Instruction latency is 5 cycles.
- MULT with `muldiv_busy` high 10 cycles, `mem_access`=0:
  - `exec2` held 11 cycles, `data_enable`=0 throughout.
- `pc_halt`=1 in FETCH:
  - `instr_read`=0, and `active` drops on the next edge.
  - 20 further cycles show no strobes and both counters frozen.
  - `reset` then restores `active`=1 and FETCH.
- Assert `reset` during an EXEC2 stall:
  - All strobes are 0 in the reset cycle.
  - The next cycle is FETCH with `instr_read`=1.
